instr_fetch_unit: RTL and testbench

Instruction fetch front end for the single-issue MIPS core. It drives word addresses to instruction memory over a req/ack handshake and buffers returned words with their PCs in a small prefetch FIFO. It presents them to the decoder/datapath over a valid/ready interface. Jumps, taken branches and `jr` are applied through a redirect port that flushes the buffer and restarts fetch at the new PC.

---
 rtl/instr_fetch_unit_if.sv | 54 +++++
 rtl/instr_fetch_unit.sv | 187 ++++++++++++++++++
 tb/tb_instr_fetch_unit.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_unit_if
// Description : Bundles the instruction-memory request/ack bus, the
//               decoder-side valid/ready stream and the redirect port of the
//               instruction fetch unit.
// Revision    : 1.0 - initial release
// ============================================================================
interface instr_fetch_unit_if;
    // Instruction memory side
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    // Decoder / datapath side
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;

    // Control-flow redirect
    logic        redirect;
    logic [31:0] redirect_pc;

    // Fetch unit view
    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata,
        output instr,
        output instr_pc,
        output instr_valid,
        input  instr_ready,
        input  redirect,
        input  redirect_pc
    );

    // Memory / consumer / control view
    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata,
        input  instr,
        input  instr_pc,
        input  instr_valid,
        output instr_ready,
        output redirect,
        output redirect_pc
    );
endinterface
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_unit
// Description : Instruction fetch front end. Issues word fetches over a
//               req/ack bus under a credit limit, buffers returned words with
//               their PCs in a prefetch FIFO and presents the FIFO head on a
//               valid/ready stream. Redirects flush the FIFO and restart
//               fetch, draining a request that is already in flight.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 4
) (
    input wire logic           clk,
    input wire logic           reset,   // asynchronous, active low
    instr_fetch_unit_if.master bus
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] c_depth    = CW'(DEPTH);
    localparam logic [CW-1:0] c_cnt_one  = CW'(1);
    localparam logic [PW-1:0] c_ptr_one  = PW'(1);
    localparam logic [31:0]   c_reset_pc = {RESET_PC[31:2], 2'b00};

    // FETCH : no request in flight, issue when credit allows
    // WAIT  : a request is in flight and its data will be kept
    // DRAIN : a request is in flight but its data belongs to a dead path
    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic            req_q, req_d;
    logic [31:0]     addr_q, addr_d;           // address currently on the bus
    logic [31:0]     fetch_pc_q, fetch_pc_d;   // PC of in-flight or next fetch
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [31:0]     fifo_instr_q [DEPTH];
    logic [31:0]     fifo_pc_q    [DEPTH];

    logic            w_valid;
    logic            w_pop;
    logic            w_ack;
    logic            w_push;
    logic            w_flush;
    logic [31:0]     w_target;
    logic [31:0]     w_pc_inc;
    logic [CW-1:0]   w_count_popped;
    logic            w_unused_lsb;

    assign w_valid        = (count_q != '0);
    assign w_pop          = w_valid & bus.instr_ready;
    assign w_ack          = req_q & bus.imem_ack;
    assign w_target       = {bus.redirect_pc[31:2], 2'b00};
    assign w_pc_inc       = fetch_pc_q + 32'd4;
    assign w_count_popped = count_q - {{(CW-1){1'b0}}, w_pop};
    assign w_unused_lsb   = ^bus.redirect_pc[1:0];

    // State and fetch-address registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_FETCH;
            req_q      <= 1'b0;
            addr_q     <= c_reset_pc;
            fetch_pc_q <= c_reset_pc;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            addr_q     <= addr_d;
            fetch_pc_q <= fetch_pc_d;
        end
    end

    // Next-state, request and push/flush decisions; redirect overrides all
    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        addr_d     = addr_q;
        fetch_pc_d = fetch_pc_q;
        w_push     = 1'b0;
        w_flush    = 1'b0;

        if (bus.redirect) begin
            w_flush    = 1'b1;
            fetch_pc_d = w_target;
            if (req_q && !bus.imem_ack) begin
                // Bus must stay stable until ack: keep old req/addr, drain it
                state_d = S_DRAIN;
            end else begin
                // FIFO is empty after the flush, so credit is always there
                state_d = S_WAIT;
                req_d   = 1'b1;
                addr_d  = w_target;
            end
        end else begin
            unique case (state_q)
                S_FETCH: begin
                    if (w_count_popped < c_depth) begin
                        state_d = S_WAIT;
                        req_d   = 1'b1;
                        addr_d  = fetch_pc_q;
                    end
                end
                S_WAIT: begin
                    if (w_ack) begin
                        w_push     = 1'b1;
                        fetch_pc_d = w_pc_inc;
                        addr_d     = w_pc_inc;
                        if ((w_count_popped + c_cnt_one) < c_depth) begin
                            req_d = 1'b1;   // back-to-back fetch
                        end else begin
                            req_d   = 1'b0;
                            state_d = S_FETCH;
                        end
                    end
                end
                S_DRAIN: begin
                    if (w_ack) begin
                        // Stale data dropped; fetch_pc already holds the target
                        state_d = S_WAIT;
                        req_d   = 1'b1;
                        addr_d  = fetch_pc_q;
                    end
                end
                default: begin
                    state_d = S_FETCH;
                    req_d   = 1'b0;
                    addr_d  = fetch_pc_q;
                end
            endcase
        end
    end

    // FIFO pointer and occupancy update
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (w_flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (w_pop) begin
                rd_ptr_d = rd_ptr_q + c_ptr_one;
            end
            if (w_push) begin
                wr_ptr_d = wr_ptr_q + c_ptr_one;
            end
            count_d = w_count_popped + {{(CW-1){1'b0}}, w_push};
        end
    end

    // FIFO control registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // FIFO storage; contents are only observed through count/pointers
    always_ff @(posedge clk) begin
        if (w_push) begin
            fifo_instr_q[wr_ptr_q] <= bus.imem_rdata;
            fifo_pc_q[wr_ptr_q]    <= fetch_pc_q;
        end
    end

    assign bus.imem_req    = req_q;
    assign bus.imem_addr   = addr_q;
    assign bus.instr_valid = w_valid;
    assign bus.instr       = w_valid ? fifo_instr_q[rd_ptr_q] : 32'd0;
    assign bus.instr_pc    = w_valid ? fifo_pc_q[rd_ptr_q]    : 32'd0;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch_unit
// Description : Self-checking bench for instr_fetch_unit. A transaction-level
//               model tracks the expected instruction stream, FIFO occupancy
//               and next fetch address; directed scenarios are followed by a
//               randomized phase.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam int          D      = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;

    instr_fetch_unit_if bus();

    instr_fetch_unit #(
        .RESET_PC (RST_PC),
        .DEPTH    (D)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: the consumer must see a contiguous PC stream starting
    // at the last redirect target; memory content is a fixed hash of address.
    logic [31:0] m_exp_pc;     // PC expected at the FIFO head
    logic [31:0] m_next_req;   // address of the next fresh request
    logic [31:0] m_out_addr;   // address of the request held on the bus
    int          m_count;      // words buffered
    bit          m_out;        // a request is held, not yet acked
    bit          m_drain;      // the held request is cancelled
    bit          m_exp_req;    // imem_req expected this cycle

    function automatic logic [31:0] mdata(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_exp_pc   = RST_PC;
        m_next_req = RST_PC;
        m_out_addr = RST_PC;
        m_count    = 0;
        m_out      = 1'b0;
        m_drain    = 1'b0;
        m_exp_req  = 1'b0;
    endtask

    // Compare all DUT outputs of the current cycle with the model
    task automatic cycle_checks();
        check("req", {31'd0, bus.imem_req}, {31'd0, m_exp_req});
        check("addr_align", {30'd0, bus.imem_addr[1:0]}, 32'd0);
        if (m_out) check("addr_hold", bus.imem_addr, m_out_addr);
        else       check("addr_next", bus.imem_addr, m_next_req);
        check("valid", {31'd0, bus.instr_valid}, {31'd0, (m_count != 0)});
        if (m_count != 0) begin
            check("head_pc", bus.instr_pc, m_exp_pc);
            check("head_instr", bus.instr, mdata(m_exp_pc));
        end else begin
            check("empty_pc", bus.instr_pc, 32'd0);
            check("empty_instr", bus.instr, 32'd0);
        end
    endtask

    // Drive one cycle of inputs, advance the model across the edge, then
    // check the DUT outputs of the following cycle.
    task automatic step(input bit ack, input bit rdy, input bit rd, input logic [31:0] rpc);
        logic [31:0] cur_addr;
        logic [31:0] tgt;
        bit          a;
        cur_addr        = m_out ? m_out_addr : m_next_req;
        a               = ack && m_exp_req;
        bus.imem_ack    = a;
        bus.imem_rdata  = a ? mdata(cur_addr) : 32'hDEAD_BEEF;
        bus.instr_ready = rdy;
        bus.redirect    = rd;
        bus.redirect_pc = rpc;

        if (rdy && m_count != 0) begin
            m_exp_pc = m_exp_pc + 32'd4;
            m_count--;
        end
        if (rd) begin
            tgt        = {rpc[31:2], 2'b00};
            m_count    = 0;
            m_exp_pc   = tgt;
            m_next_req = tgt;
            m_drain    = m_exp_req && !a;
        end else if (a) begin
            if (m_drain) begin
                m_drain = 1'b0;
            end else begin
                m_count++;
                m_next_req = cur_addr + 32'd4;
            end
        end
        m_out      = m_exp_req && !a;
        m_out_addr = cur_addr;
        m_exp_req  = m_out || (m_count < D);

        @(posedge clk);
        #1;
        cycle_checks();
    endtask

    // Assert reset (asynchronously), check outputs at once, release after 2 edges
    task automatic do_reset();
        bus.imem_ack    = 1'b0;
        bus.imem_rdata  = 32'd0;
        bus.instr_ready = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 32'd0;
        reset = 1'b0;
        #1;
        model_reset();
        check("rst_req", {31'd0, bus.imem_req}, 32'd0);
        check("rst_valid", {31'd0, bus.instr_valid}, 32'd0);
        check("rst_instr", bus.instr, 32'd0);
        check("rst_pc", bus.instr_pc, 32'd0);
        check("rst_addr", bus.imem_addr, RST_PC);
        repeat (2) @(posedge clk);
        #1;
        cycle_checks();
        reset = 1'b1;
    endtask

    int          n;
    logic [31:0] rpc;

    initial begin
        #2;
        // ---- Sequential fetch, single-cycle ack, consumer always ready ----
        do_reset();
        step(1'b0, 1'b1, 1'b0, 32'd0);
        check("first_req", {31'd0, bus.imem_req}, 32'd1);
        check("first_addr", bus.imem_addr, RST_PC);
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b1, 1'b0, 32'd0);
            check("seq_addr", bus.imem_addr, 32'(4 * (i + 1)));
            check("seq_pc", bus.instr_pc, 32'(4 * i));
            check("seq_valid", {31'd0, bus.instr_valid}, 32'd1);
        end

        // ---- Consumer stalled: exactly DEPTH requests, then in-order drain ----
        do_reset();
        step(1'b0, 1'b0, 1'b0, 32'd0);
        n = 0;
        for (int i = 0; i < 8; i++) begin
            if (bus.imem_req) n++;
            step(1'b1, 1'b0, 1'b0, 32'd0);
        end
        check("full_reqs", n, D);
        check("full_req_low", {31'd0, bus.imem_req}, 32'd0);
        check("full_addr", bus.imem_addr, 32'd16);
        for (int k = 0; k < 4; k++) begin
            check("drain_pc", bus.instr_pc, 32'(4 * k));
            step(1'b0, 1'b1, 1'b0, 32'd0);
        end
        check("resume_req", {31'd0, bus.imem_req}, 32'd1);
        check("resume_addr", bus.imem_addr, 32'd16);

        // ---- Redirect while a request is waiting for a delayed ack ----
        do_reset();
        step(1'b0, 1'b1, 1'b0, 32'd0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 32'd0);
        check("pre_redir_addr", bus.imem_addr, 32'h10);
        step(1'b0, 1'b1, 1'b1, 32'h100);
        check("drain_valid", {31'd0, bus.instr_valid}, 32'd0);
        check("drain_addr0", bus.imem_addr, 32'h10);
        step(1'b0, 1'b1, 1'b0, 32'd0);
        check("drain_addr1", bus.imem_addr, 32'h10);
        step(1'b0, 1'b1, 1'b0, 32'd0);
        check("drain_addr2", bus.imem_addr, 32'h10);
        step(1'b1, 1'b1, 1'b0, 32'd0);
        check("post_drain_addr", bus.imem_addr, 32'h100);
        check("post_drain_valid", {31'd0, bus.instr_valid}, 32'd0);
        step(1'b1, 1'b1, 1'b0, 32'd0);
        check("target_pc", bus.instr_pc, 32'h100);
        check("target_instr", bus.instr, mdata(32'h100));

        // ---- Redirect coincident with ack and pop, unaligned target ----
        step(1'b1, 1'b1, 1'b1, 32'h203);
        check("coinc_valid", {31'd0, bus.instr_valid}, 32'd0);
        check("coinc_addr", bus.imem_addr, 32'h200);
        check("coinc_req", {31'd0, bus.imem_req}, 32'd1);

        // ---- Address wrap at the top of the address space ----
        step(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF);
        check("wrap_addr0", bus.imem_addr, 32'hFFFF_FFFC);
        step(1'b1, 1'b1, 1'b0, 32'd0);
        check("wrap_addr1", bus.imem_addr, 32'h0000_0000);
        check("wrap_pc", bus.instr_pc, 32'hFFFF_FFFC);

        // ---- Reset mid-burst with 3 buffered entries ----
        do_reset();
        step(1'b0, 1'b0, 1'b0, 32'd0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 32'd0);
        check("burst_req", {31'd0, bus.imem_req}, 32'd1);
        do_reset();
        step(1'b0, 1'b1, 1'b0, 32'd0);
        check("restart_addr", bus.imem_addr, RST_PC);
        check("restart_req", {31'd0, bus.imem_req}, 32'd1);

        // ---- Randomized traffic against the model ----
        for (int i = 0; i < 600; i++) begin
            rpc = ($urandom % 4 == 0) ? (32'hFFFF_FFF0 | ($urandom % 16)) : $urandom;
            step(($urandom % 3) != 0, ($urandom % 4) != 0, ($urandom % 12) == 0, rpc);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
